// File: rtl/button_conditioner.sv
// Pushbutton conditioner: 2-FF synchronizer, debounce FSM, press/release/long-press strobes, press counter.
// Accepted level change appears DEBOUNCE_CYCLES+3 edges after the pin settles; every output is registered.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int LONG_CYCLES     = 50_000_000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic [7:0] press_count
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);

  typedef enum logic [1:0] {IDLE, ARM, PRESSED, DISARM} state_t;

  state_t              state;
  logic                s1, s2;
  logic                btn_s;
  logic [CNT_W-1:0]    cnt;
  logic [HOLD_W-1:0]   hold;
  logic                long_done;

  // Sync flops reset to the idle pin level so a held button is seen as a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= ACTIVE_LOW;
      s2 <= ACTIVE_LOW;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
    end
  end

  assign btn_s = s2 ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      cnt           <= '0;
      hold          <= '0;
      long_done     <= 1'b0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      press_count   <= 8'd0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;

      // Hold timer runs through DISARM so a bouncy release cannot restart the long-press window.
      if (state == PRESSED || state == DISARM) begin
        if (hold != HOLD_MAX) hold <= hold + 1'b1;
        if (hold == HOLD_LAST && !long_done) begin
          long_pulse <= 1'b1;
          long_done  <= 1'b1;
        end
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (btn_s) state <= ARM;
        end
        ARM: begin
          if (!btn_s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= PRESSED;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
            press_count <= press_count + 8'd1;
            hold        <= '0;
            long_done   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESSED: begin
          cnt <= '0;
          if (!btn_s) state <= DISARM;
        end
        DISARM: begin
          if (btn_s) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
            cnt           <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: run-length debounce model checked every cycle, plus directed literal checks.
module tb_button_conditioner;
  localparam int D = 4;
  localparam int L = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_raw = 1'b1;
  logic       btn_level, press_pulse, release_pulse, long_pulse;
  logic [7:0] press_count;

  int tests = 0;
  int fails = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .btn_level(btn_level),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .press_count(press_count)
  );

  always #5 clk = ~clk;

  // Model: level flips once the synchronized pin disagrees with it for D+1 consecutive edges;
  // long strobe lands L edges after the accepted press if the level is still held.
  bit m_s1, m_s2, m_level, m_press, m_rel, m_long, started;
  int m_run, m_edge, m_press_edge, m_count;

  always @(posedge clk) begin
    bit bs;
    bit lvl_before;
    started = 1'b1;
    m_press = 1'b0;
    m_rel   = 1'b0;
    m_long  = 1'b0;
    if (reset) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      m_level = 1'b0; m_run = 0; m_count = 0; m_edge = 0; m_press_edge = -1000;
    end else begin
      m_edge++;
      bs   = ~m_s2;
      m_s2 = m_s1;
      m_s1 = btn_raw;
      lvl_before = m_level;
      if (lvl_before && (m_edge - m_press_edge == L)) m_long = 1'b1;
      if (bs != m_level) m_run++; else m_run = 0;
      if (m_run == D + 1) begin
        m_level = ~m_level;
        m_run   = 0;
        if (m_level) begin
          m_press      = 1'b1;
          m_count      = (m_count + 1) % 256;
          m_press_edge = m_edge;
        end else begin
          m_rel = 1'b1;
        end
      end
    end
  end

  int n_press = 0, n_rel = 0, n_long = 0;
  int last_press_edge = 0, last_rel_edge = 0, last_long_edge = 0;

  always @(negedge clk) begin
    if (started) begin
      tests++;
      if ({btn_level, press_pulse, release_pulse, long_pulse, press_count} !==
          {m_level, m_press, m_rel, m_long, 8'(m_count)}) begin
        fails++;
        $display("FAIL model_cmp edge=%0d got lvl=%b p=%b r=%b l=%b cnt=%0d want lvl=%b p=%b r=%b l=%b cnt=%0d",
                 m_edge, btn_level, press_pulse, release_pulse, long_pulse, press_count,
                 m_level, m_press, m_rel, m_long, m_count);
      end
      if (press_pulse === 1'b1)   begin n_press++; last_press_edge = m_edge; end
      if (release_pulse === 1'b1) begin n_rel++;   last_rel_edge   = m_edge; end
      if (long_pulse === 1'b1)    begin n_long++;  last_long_edge  = m_edge; end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_press(input int bound);
    int start;
    start = n_press;
    for (int i = 0; i < bound; i++) begin
      step(1);
      if (n_press != start) break;
    end
    chk("press_within_bound", n_press - start, 1);
  endtask

  int p0, r0, l0, e0;

  initial begin
    reset = 1'b1; btn_raw = 1'b1;
    step(3);
    chk("reset_level", btn_level, 0);
    chk("reset_count", press_count, 0);
    chk("reset_pulses", {press_pulse, release_pulse, long_pulse}, 0);
    reset = 1'b0;
    step(6);

    // Glitches of 3 and D cycles are rejected; D+1 cycles is accepted.
    p0 = n_press; r0 = n_rel;
    btn_raw = 1'b0; step(3); btn_raw = 1'b1; step(10);
    chk("glitch3_press", n_press - p0, 0);
    chk("glitch3_level", btn_level, 0);
    chk("glitch3_count", press_count, 0);
    btn_raw = 1'b0; step(4); btn_raw = 1'b1; step(10);
    chk("glitch4_press", n_press - p0, 0);
    btn_raw = 1'b0; step(5); btn_raw = 1'b1; step(12);
    chk("glitch5_press", n_press - p0, 1);
    chk("glitch5_release", n_rel - r0, 1);

    // Reset with the button held, then first press after release.
    reset = 1'b1; btn_raw = 1'b0;
    step(3);
    chk("held_reset_level", btn_level, 0);
    chk("held_reset_count", press_count, 0);
    reset = 1'b0;
    l0 = n_long;
    wait_press(20);
    chk("first_press_edge", last_press_edge, 7);
    chk("first_press_count", press_count, 1);
    step(29);
    chk("long_once", n_long - l0, 1);
    chk("long_delay", last_long_edge - last_press_edge, 20);
    chk("held_level", btn_level, 1);

    // Release with a 2-cycle re-press bounce in the middle of debounce.
    p0 = n_press; r0 = n_rel;
    btn_raw = 1'b1; step(3);
    btn_raw = 1'b0; step(2);
    chk("bounce_no_release", n_rel - r0, 0);
    btn_raw = 1'b1; e0 = m_edge;
    step(12);
    chk("bounce_release_once", n_rel - r0, 1);
    chk("bounce_release_edge", last_rel_edge - e0, 7);
    chk("bounce_no_press", n_press - p0, 0);
    chk("released_level", btn_level, 0);

    // Reset while PRESSED with the button still held.
    btn_raw = 1'b0;
    wait_press(20);
    step(3);
    r0 = n_rel;
    reset = 1'b1; step(1);
    chk("rst_pressed_level", btn_level, 0);
    chk("rst_pressed_count", press_count, 0);
    reset = 1'b0;
    wait_press(20);
    chk("rst_no_release", n_rel - r0, 0);
    chk("repress_edge", last_press_edge, 7);
    chk("repress_count", press_count, 1);

    // 256 clean press/release pairs wrap the counter back to zero.
    reset = 1'b1; btn_raw = 1'b1; step(2);
    reset = 1'b0; step(3);
    p0 = n_press; r0 = n_rel;
    for (int i = 0; i < 256; i++) begin
      btn_raw = 1'b0; step(10);
      btn_raw = 1'b1; step(10);
    end
    chk("wrap_count", press_count, 0);
    chk("wrap_presses", n_press - p0, 256);
    chk("wrap_releases", n_rel - r0, 256);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
